// File: rtl/csr_defs_pkg.sv
// csr_defs: shared constants and types for the writeback-side CSR controller.
//   - CSR numbers used by the controller and its test environment
//   - ws_op encodings presented by the WB stage
//   - default exception codes
//   - controller FSM state encoding
package csr_defs;

  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_EENTRY = 14'hC;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_CSRRD   = 3'd1,
    OP_CSRWR   = 3'd2,
    OP_CSRXCHG = 3'd3,
    OP_ERTN    = 3'd4,
    OP_SYSCALL = 3'd5,
    OP_UND6    = 3'd6,
    OP_UND7    = 3'd7
  } ws_op_e;

  localparam logic [5:0] EC_SYS = 6'h0B;
  localparam logic [5:0] EC_INE = 6'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_COMMIT,
    ST_EXC,
    ST_VEC,
    ST_ERTN,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/csr_ctrl.sv
// csr_ctrl: writeback-side CSR / exception controller.
// Accepts one retiring instruction per handshake from WB and sequences:
//   csrrd/csrwr/csrxchg : READ (capture old value) -> COMMIT (masked write, GPR writeback)
//   exception / syscall : EXC (wb_ex pulse) -> VEC (read EENTRY, flush)
//   ertn                : ERTN (ertn pulse, capture ERA) -> FLUSH (flush to ERA)
// Ports:
//   clk, rst                       clock, async active-high reset
//   ws_valid/ws_ready              WB handshake (ready only in IDLE)
//   ws_pc, ws_op, ws_csr_num       instruction PC, operation, CSR number
//   ws_rd_val, ws_rj_val           write data and csrxchg mask
//   ws_ex, ws_ecode                upstream exception flag and code
//   csr_raddr/csr_rdata            regfile read port (combinational data)
//   csr_we/csr_waddr/csr_wdata     regfile per-bit masked write port
//   csr_ertn, csr_wb_ex            one-cycle ertn / exception pulses
//   csr_wb_pc, csr_ecode           exception PC and code
//   rf_we, rf_wdata                GPR writeback of the old CSR value
//   flush, flush_target            one-cycle flush pulse and redirect PC
module csr_ctrl
  import csr_defs::*;
#(
  parameter logic [5:0] ECODE_SYS = 6'h0B,
  parameter logic [5:0] ECODE_INE = 6'h0D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ws_valid,
  output logic        ws_ready,
  input  logic [31:0] ws_pc,
  input  logic [2:0]  ws_op,
  input  logic [13:0] ws_csr_num,
  input  logic [31:0] ws_rd_val,
  input  logic [31:0] ws_rj_val,
  input  logic        ws_ex,
  input  logic [5:0]  ws_ecode,
  output logic [13:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic [31:0] csr_we,
  output logic [13:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        csr_ertn,
  output logic        csr_wb_ex,
  output logic [31:0] csr_wb_pc,
  output logic [5:0]  csr_ecode,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic [31:0] flush_target
);

  state_e      state_reg, state_next;
  ws_op_e      op_reg;
  logic [13:0] num_reg;
  logic [31:0] pc_reg;
  logic [31:0] rd_reg;
  logic [31:0] rj_reg;
  logic [5:0]  code_reg;
  logic [31:0] old_reg;
  logic [31:0] era_reg;

  logic   accept;
  ws_op_e op_in;
  logic   take_exc;

  assign op_in    = ws_op_e'(ws_op);
  assign accept   = ws_valid && (state_reg == ST_IDLE);
  // Upstream exceptions outrank syscall, which outranks an undefined op.
  assign take_exc = ws_ex || (op_in == OP_SYSCALL) || (op_in == OP_UND6) || (op_in == OP_UND7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg   <= OP_NONE;
      num_reg  <= '0;
      pc_reg   <= '0;
      rd_reg   <= '0;
      rj_reg   <= '0;
      code_reg <= '0;
      old_reg  <= '0;
      era_reg  <= '0;
    end else begin
      if (accept) begin
        op_reg  <= op_in;
        num_reg <= ws_csr_num;
        pc_reg  <= ws_pc;
        rd_reg  <= ws_rd_val;
        rj_reg  <= ws_rj_val;
        if (ws_ex) begin
          code_reg <= ws_ecode;
        end else if (op_in == OP_SYSCALL) begin
          code_reg <= ECODE_SYS;
        end else begin
          code_reg <= ECODE_INE;
        end
      end
      if (state_reg == ST_READ) begin
        old_reg <= csr_rdata;
      end
      if (state_reg == ST_ERTN) begin
        era_reg <= csr_rdata;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    ws_ready     = 1'b0;
    csr_raddr    = '0;
    csr_we       = '0;
    csr_waddr    = '0;
    csr_wdata    = '0;
    csr_ertn     = 1'b0;
    csr_wb_ex    = 1'b0;
    csr_wb_pc    = '0;
    csr_ecode    = '0;
    rf_we        = 1'b0;
    rf_wdata     = '0;
    flush        = 1'b0;
    flush_target = '0;

    case (state_reg)
      ST_IDLE: begin
        ws_ready = 1'b1;
        if (accept) begin
          if (take_exc) begin
            state_next = ST_EXC;
          end else if (op_in == OP_ERTN) begin
            state_next = ST_ERTN;
          end else if (op_in != OP_NONE) begin
            state_next = ST_READ;
          end
        end
      end
      ST_READ: begin
        csr_raddr  = num_reg;
        state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        rf_we     = 1'b1;
        rf_wdata  = old_reg;
        csr_waddr = num_reg;
        if (op_reg == OP_CSRWR) begin
          csr_we    = 32'hFFFF_FFFF;
          csr_wdata = rd_reg;
        end else if (op_reg == OP_CSRXCHG) begin
          csr_we    = rj_reg;
          csr_wdata = rd_reg;
        end
        state_next = ST_IDLE;
      end
      ST_EXC: begin
        csr_wb_ex  = 1'b1;
        csr_wb_pc  = pc_reg;
        csr_ecode  = code_reg;
        state_next = ST_VEC;
      end
      ST_VEC: begin
        // EENTRY is read one cycle after wb_ex so the regfile has already
        // committed the exception entry.
        csr_raddr    = CSR_EENTRY;
        flush        = 1'b1;
        flush_target = csr_rdata;
        state_next   = ST_IDLE;
      end
      ST_ERTN: begin
        csr_ertn   = 1'b1;
        csr_raddr  = CSR_ERA;
        state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush        = 1'b1;
        flush_target = era_reg;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_ctrl.sv
module tb_csr_ctrl;

  logic        clk;
  logic        rst;
  logic        ws_valid;
  logic        ws_ready;
  logic [31:0] ws_pc;
  logic [2:0]  ws_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rd_val;
  logic [31:0] ws_rj_val;
  logic        ws_ex;
  logic [5:0]  ws_ecode;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [31:0] csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_ertn;
  logic        csr_wb_ex;
  logic [31:0] csr_wb_pc;
  logic [5:0]  csr_ecode;
  logic        rf_we;
  logic [31:0] rf_wdata;
  logic        flush;
  logic [31:0] flush_target;

  int checks = 0;
  int errors = 0;

  // Simple CSR regfile model: combinational read, per-bit masked write,
  // plus a bench-side preload port.
  logic [31:0] mem [0:16383];
  logic        pre_we;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;

  assign csr_rdata = mem[csr_raddr];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    for (int i = 0; i < 32; i++) begin
      if (csr_we[i]) mem[csr_waddr][i] <= csr_wdata[i];
    end
  end

  csr_ctrl dut (
    .clk(clk), .rst(rst),
    .ws_valid(ws_valid), .ws_ready(ws_ready),
    .ws_pc(ws_pc), .ws_op(ws_op), .ws_csr_num(ws_csr_num),
    .ws_rd_val(ws_rd_val), .ws_rj_val(ws_rj_val),
    .ws_ex(ws_ex), .ws_ecode(ws_ecode),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_ertn(csr_ertn), .csr_wb_ex(csr_wb_ex),
    .csr_wb_pc(csr_wb_pc), .csr_ecode(csr_ecode),
    .rf_we(rf_we), .rf_wdata(rf_wdata),
    .flush(flush), .flush_target(flush_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [13:0] addr, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    step();
    pre_we   = 1'b0;
  endtask

  // Presents one instruction, checks it is offered in IDLE, and returns at T+1.
  task automatic issue(input logic [2:0] op, input logic [13:0] num, input logic [31:0] pc,
                       input logic [31:0] rd, input logic [31:0] rj,
                       input logic ex, input logic [5:0] ecode);
    ws_valid   = 1'b1;
    ws_op      = op;
    ws_csr_num = num;
    ws_pc      = pc;
    ws_rd_val  = rd;
    ws_rj_val  = rj;
    ws_ex      = ex;
    ws_ecode   = ecode;
    check("ready_before_accept", {31'd0, ws_ready}, 32'd1);
    step();
    ws_valid = 1'b0;
    ws_ex    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ws_valid = 1'b0; ws_op = '0; ws_csr_num = '0; ws_pc = '0;
    ws_rd_val = '0; ws_rj_val = '0; ws_ex = 1'b0; ws_ecode = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    step();
    step();
    check("rst_ready", {31'd0, ws_ready}, 32'd1);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_we", csr_we, 32'd0);
    check("rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("rst_wb_ex", {31'd0, csr_wb_ex}, 32'd0);
    rst = 1'b0;
    $display("txn reset");

    preload(14'h30, 32'h0000_0011);
    preload(14'h31, 32'hFFFF_0000);
    preload(14'h32, 32'hA5A5_A5A5);
    preload(14'h33, 32'h3333_3333);
    preload(14'h0C, 32'h1C00_8000);
    preload(14'h06, 32'h1C00_0104);

    // csrwr SAVE0
    issue(3'd2, 14'h30, 32'h1C00_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 6'h0);
    check("wr_read_addr", {18'd0, csr_raddr}, 32'h30);
    check("wr_read_ready", {31'd0, ws_ready}, 32'd0);
    check("wr_read_we", csr_we, 32'd0);
    step();
    check("wr_we", csr_we, 32'hFFFF_FFFF);
    check("wr_wdata", csr_wdata, 32'hDEAD_BEEF);
    check("wr_waddr", {18'd0, csr_waddr}, 32'h30);
    check("wr_rf_we", {31'd0, rf_we}, 32'd1);
    check("wr_rf_wdata", rf_wdata, 32'h0000_0011);
    step();
    check("wr_idle_ready", {31'd0, ws_ready}, 32'd1);
    check("wr_idle_rf_we", {31'd0, rf_we}, 32'd0);
    check("wr_save0", mem[14'h30], 32'hDEAD_BEEF);
    $display("txn csrwr SAVE0");

    // csrxchg SAVE1
    issue(3'd3, 14'h31, 32'h1C00_0004, 32'h1234_5678, 32'h0000_FFFF, 1'b0, 6'h0);
    step();
    check("xchg_we", csr_we, 32'h0000_FFFF);
    check("xchg_wdata", csr_wdata, 32'h1234_5678);
    check("xchg_rf_wdata", rf_wdata, 32'hFFFF_0000);
    step();
    check("xchg_save1", mem[14'h31], 32'hFFFF_5678);
    $display("txn csrxchg SAVE1");

    // csrrd SAVE0
    issue(3'd1, 14'h30, 32'h1C00_0008, 32'h0BAD_0BAD, 32'hFFFF_FFFF, 1'b0, 6'h0);
    step();
    check("rd_we", csr_we, 32'd0);
    check("rd_rf_we", {31'd0, rf_we}, 32'd1);
    check("rd_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    step();
    check("rd_save0", mem[14'h30], 32'hDEAD_BEEF);
    $display("txn csrrd SAVE0");

    // syscall
    issue(3'd5, 14'h0, 32'h1C00_0100, 32'h0, 32'h0, 1'b0, 6'h0);
    check("sys_wb_ex", {31'd0, csr_wb_ex}, 32'd1);
    check("sys_ecode", {26'd0, csr_ecode}, 32'h0B);
    check("sys_wb_pc", csr_wb_pc, 32'h1C00_0100);
    check("sys_no_flush", {31'd0, flush}, 32'd0);
    step();
    check("sys_flush", {31'd0, flush}, 32'd1);
    check("sys_target", flush_target, 32'h1C00_8000);
    check("sys_vec_addr", {18'd0, csr_raddr}, 32'h0C);
    check("sys_wb_ex_off", {31'd0, csr_wb_ex}, 32'd0);
    step();
    check("sys_flush_off", {31'd0, flush}, 32'd0);
    check("sys_ready", {31'd0, ws_ready}, 32'd1);
    $display("txn syscall");

    // ertn with a csrwr held on ws_valid while busy
    issue(3'd4, 14'h0, 32'h1C00_0200, 32'h0, 32'h0, 1'b0, 6'h0);
    ws_valid = 1'b1; ws_op = 3'd2; ws_csr_num = 14'h32; ws_rd_val = 32'h0;
    check("ertn_pulse", {31'd0, csr_ertn}, 32'd1);
    check("ertn_addr", {18'd0, csr_raddr}, 32'h06);
    check("ertn_ready", {31'd0, ws_ready}, 32'd0);
    step();
    check("ertn_flush", {31'd0, flush}, 32'd1);
    check("ertn_target", flush_target, 32'h1C00_0104);
    check("ertn_pulse_off", {31'd0, csr_ertn}, 32'd0);
    check("ertn_flush_ready", {31'd0, ws_ready}, 32'd0);
    ws_valid = 1'b0;
    step();
    check("ertn_idle_ready", {31'd0, ws_ready}, 32'd1);
    check("ertn_idle_raddr", {18'd0, csr_raddr}, 32'd0);
    step();
    check("ertn_held_rf_we", {31'd0, rf_we}, 32'd0);
    check("ertn_held_save2", mem[14'h32], 32'hA5A5_A5A5);
    $display("txn ertn with held valid");

    // upstream exception beats csrwr
    issue(3'd2, 14'h33, 32'h1C00_0300, 32'h7777_7777, 32'h0, 1'b1, 6'h08);
    check("prio_wb_ex", {31'd0, csr_wb_ex}, 32'd1);
    check("prio_ecode", {26'd0, csr_ecode}, 32'h08);
    check("prio_we_exc", csr_we, 32'd0);
    step();
    check("prio_flush", {31'd0, flush}, 32'd1);
    check("prio_we_vec", csr_we, 32'd0);
    step();
    check("prio_save3", mem[14'h33], 32'h3333_3333);
    $display("txn priority ws_ex over csrwr");

    // undefined op
    issue(3'd6, 14'h0, 32'h1C00_0400, 32'h0, 32'h0, 1'b0, 6'h0);
    check("ine_wb_ex", {31'd0, csr_wb_ex}, 32'd1);
    check("ine_ecode", {26'd0, csr_ecode}, 32'h0D);
    check("ine_wb_pc", csr_wb_pc, 32'h1C00_0400);
    step();
    step();
    $display("txn undefined op");

    // op none retires with no side effect
    issue(3'd0, 14'h30, 32'h1C00_0500, 32'h0, 32'h0, 1'b0, 6'h0);
    check("none_ready", {31'd0, ws_ready}, 32'd1);
    check("none_rf_we", {31'd0, rf_we}, 32'd0);
    check("none_wb_ex", {31'd0, csr_wb_ex}, 32'd0);
    check("none_raddr", {18'd0, csr_raddr}, 32'd0);
    $display("txn op none");

    // reset asserted mid-sequence (during READ of a csrwr)
    issue(3'd2, 14'h33, 32'h1C00_0600, 32'h5555_5555, 32'h0, 1'b0, 6'h0);
    check("mid_read_addr", {18'd0, csr_raddr}, 32'h33);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, ws_ready}, 32'd1);
    check("mid_rst_raddr", {18'd0, csr_raddr}, 32'd0);
    check("mid_rst_we", csr_we, 32'd0);
    check("mid_rst_flush", {31'd0, flush}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("mid_rst_rf_we", {31'd0, rf_we}, 32'd0);
    check("mid_rst_save3", mem[14'h33], 32'h3333_3333);
    $display("txn reset mid-sequence");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
